// File: rtl/gt_refclk_obufds.sv
// GT reference-clock differential output buffer.
// Glitch-free enable/disable with optional power-of-two divider.
module gt_refclk_obufds #(
  parameter bit         REFCLK_EN_TX_PATH = 1'b0,
  parameter logic [4:0] REFCLK_ICNTL_TX   = 5'b00000,
  parameter int         REFCLK_DIV        = 1,
  parameter int         WAKE_CYCLES       = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        CEB,
  output logic        O,
  output logic        OB,
  output logic        ACTIVE,
  output logic [15:0] PULSES
);

  typedef enum logic [1:0] {
    OFF,
    WAKE,
    RUN,
    DRAIN
  } state_t;

  localparam int         K       = $clog2(REFCLK_DIV);
  localparam int         KI      = (K > 0) ? K - 1 : 0;
  localparam logic [2:0] LAST    = 3'(REFCLK_DIV - 1);
  localparam logic [7:0] WAKE_LD = 8'(WAKE_CYCLES - 1);
  // Drive strength only shapes the pad; it never gates the path.
  localparam bit PATH_EN =
    REFCLK_EN_TX_PATH && (REFCLK_ICNTL_TX <= 5'h1f);

  state_t     state, state_n;
  logic       s1, s2, ceb_s;
  logic [2:0] cnt, cnt_n;
  logic [7:0] wake_cnt, wake_n;
  logic       act_n;
  logic       pulse_inc;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= CEB;
      s2 <= s1;
    end
  end

  assign ceb_s = s2;

  always_comb begin
    state_n = state;
    wake_n  = wake_cnt;
    case (state)
      OFF: begin
        if (!ceb_s && PATH_EN) begin
          state_n = WAKE;
          wake_n  = WAKE_LD;
        end
      end
      WAKE: begin
        if (ceb_s) begin
          state_n = OFF;
        end else if (wake_cnt == 8'd0) begin
          state_n = RUN;
        end else begin
          wake_n = wake_cnt - 8'd1;
        end
      end
      RUN: begin
        if (ceb_s) state_n = DRAIN;
      end
      default: begin
        // Only leave on the last count so the period completes.
        if (!ceb_s) begin
          state_n = RUN;
        end else if (cnt == LAST) begin
          state_n = OFF;
        end
      end
    endcase
  end

  assign ACTIVE = (state == RUN) || (state == DRAIN);
  assign act_n  = (state_n == RUN) || (state_n == DRAIN);

  always_comb begin
    cnt_n = 3'd0;
    if (ACTIVE && act_n) cnt_n = (cnt + 3'd1) & LAST;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= OFF;
      cnt      <= 3'd0;
      wake_cnt <= 8'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      wake_cnt <= wake_n;
    end
  end

  generate
    if (REFCLK_DIV == 1) begin : g_pass
      logic gate;

      // Falling-edge gate keeps CLK & gate free of runts.
      always_ff @(negedge CLK or negedge RSTN) begin
        if (!RSTN) gate <= 1'b0;
        else       gate <= ACTIVE;
      end

      assign O         = CLK & gate;
      assign pulse_inc = gate;
    end else begin : g_div
      assign O         = ACTIVE & ~cnt[KI];
      assign pulse_inc = act_n && (cnt_n == 3'd0);
    end
  endgenerate

  assign OB = ~O;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)          PULSES <= 16'd0;
    else if (pulse_inc) PULSES <= PULSES + 16'd1;
  end

endmodule

// File: tb/tb_gt_refclk_obufds.sv
// Bench for gt_refclk_obufds: four configurations against
// a phase/remaining-wake behavioural model.
module tb_gt_refclk_obufds;

  logic        CLK  = 1'b0;
  logic        RSTN = 1'b0;
  logic [3:0]  ceb  = 4'hf;
  logic [3:0]  o, ob, act;
  logic [15:0] pd0, pd1, pd2, pd3;
  int          tests = 0;
  int          fails = 0;

  always #5 CLK = ~CLK;

  gt_refclk_obufds #(
    .REFCLK_EN_TX_PATH(1'b1), .REFCLK_ICNTL_TX(5'd0),
    .REFCLK_DIV(2), .WAKE_CYCLES(4)
  ) u_div2 (
    .CLK(CLK), .RSTN(RSTN), .CEB(ceb[0]), .O(o[0]),
    .OB(ob[0]), .ACTIVE(act[0]), .PULSES(pd0)
  );

  gt_refclk_obufds #(
    .REFCLK_EN_TX_PATH(1'b1), .REFCLK_ICNTL_TX(5'd7),
    .REFCLK_DIV(8), .WAKE_CYCLES(3)
  ) u_div8 (
    .CLK(CLK), .RSTN(RSTN), .CEB(ceb[1]), .O(o[1]),
    .OB(ob[1]), .ACTIVE(act[1]), .PULSES(pd1)
  );

  gt_refclk_obufds #(
    .REFCLK_EN_TX_PATH(1'b1), .REFCLK_ICNTL_TX(5'd31),
    .REFCLK_DIV(1), .WAKE_CYCLES(2)
  ) u_div1 (
    .CLK(CLK), .RSTN(RSTN), .CEB(ceb[2]), .O(o[2]),
    .OB(ob[2]), .ACTIVE(act[2]), .PULSES(pd2)
  );

  gt_refclk_obufds #(
    .REFCLK_EN_TX_PATH(1'b0), .REFCLK_ICNTL_TX(5'd0),
    .REFCLK_DIV(2), .WAKE_CYCLES(4)
  ) u_off (
    .CLK(CLK), .RSTN(RSTN), .CEB(ceb[3]), .O(o[3]),
    .OB(ob[3]), .ACTIVE(act[3]), .PULSES(pd3)
  );

  // Model: st 0=off 1=wake 2=run 3=drain; wl = wake edges left.
  int          mdiv [4] = '{2, 8, 1, 2};
  int          mwake[4] = '{4, 3, 2, 4};
  bit          men  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  int          st[4], wl[4], ph[4];
  logic [15:0] mp[4];
  bit          h1[4], h2[4], gt[4];

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < 4; i++) begin
        st[i] <= 0; wl[i] <= 0; ph[i] <= 0;
        mp[i] <= '0; h1[i] <= 1'b1; h2[i] <= 1'b1;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin : mstep
        int ns, nw, np;
        logic [15:0] npul;
        ns = st[i]; nw = wl[i]; npul = mp[i];
        case (st[i])
          0: if (!h2[i] && men[i]) begin ns = 1; nw = mwake[i]; end
          1: if (h2[i]) ns = 0;
             else if (wl[i] == 1) ns = 2;
             else nw = wl[i] - 1;
          2: if (h2[i]) ns = 3;
          default: if (!h2[i]) ns = 2;
                   else if (ph[i] == mdiv[i] - 1) ns = 0;
        endcase
        np = (st[i] >= 2 && ns >= 2) ? (ph[i] + 1) % mdiv[i] : 0;
        if (mdiv[i] == 1) begin
          if (gt[i]) npul = npul + 16'd1;
        end else if (ns >= 2 && np == 0) begin
          npul = npul + 16'd1;
        end
        st[i] <= ns; wl[i] <= nw; ph[i] <= np; mp[i] <= npul;
        h1[i] <= ceb[i]; h2[i] <= h1[i];
      end
    end
  end

  always @(negedge CLK or negedge RSTN) begin
    if (!RSTN) for (int i = 0; i < 4; i++) gt[i] <= 1'b0;
    else       for (int i = 0; i < 4; i++) gt[i] <= (st[i] >= 2);
  end

  function automatic logic [15:0] pd(input int i);
    case (i)
      0: return pd0;
      1: return pd1;
      2: return pd2;
      default: return pd3;
    endcase
  endfunction

  // Expected O sampled shortly after a rising edge.
  function automatic bit exp_o(input int i);
    if (mdiv[i] == 1) return gt[i];
    return (st[i] >= 2) && (ph[i] < mdiv[i] / 2);
  endfunction

  task automatic step_pos;
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset;
    @(negedge CLK);
    RSTN = 1'b0;
    ceb  = 4'hf;
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic test_reset;
    RSTN = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({o[i], ob[i], act[i], pd(i)} !== {3'b010, 16'd0}) begin
        fails++;
        $display("FAIL reset[%0d]: got o=%b ob=%b act=%b p=%0h want 0 1 0 0",
                 i, o[i], ob[i], act[i], pd(i));
      end
    end
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic test_default_enable;
    do_reset;
    @(negedge CLK);
    ceb[0] = 1'b0;
    for (int e = 0; e <= 24; e++) begin
      step_pos;
      if (e == 5) begin
        tests++;
        if (act[0] !== 1'b0) begin
          fails++;
          $display("FAIL en_early: got act=%b want 0", act[0]);
        end
      end
      if (e == 6) begin
        tests++;
        if ({act[0], o[0]} !== 2'b11) begin
          fails++;
          $display("FAIL en_e6: got act,o=%b%b want 11", act[0], o[0]);
        end
      end
      if (e >= 6) begin
        tests++;
        if ({o[0], ob[0]} !== {((e - 6) % 2 == 0), ((e - 6) % 2 != 0)}) begin
          fails++;
          $display("FAIL en_period e%0d: got o,ob=%b%b", e, o[0], ob[0]);
        end
      end
      if (e == 24) begin
        tests++;
        if (pd0 !== 16'd10) begin
          fails++;
          $display("FAIL en_pulses: got %0d want 10", pd0);
        end
      end
    end
  endtask

  task automatic test_tx_disabled;
    do_reset;
    @(negedge CLK);
    ceb[3] = 1'b0;
    for (int e = 0; e < 100; e++) begin
      step_pos;
      tests++;
      if ({o[3], ob[3], act[3], pd3} !== {3'b010, 16'd0}) begin
        fails++;
        $display("FAIL txdis e%0d: got o=%b ob=%b act=%b p=%0d want 0 1 0 0",
                 e, o[3], ob[3], act[3], pd3);
      end
    end
  endtask

  task automatic test_drain;
    do_reset;
    @(negedge CLK);
    ceb[1] = 1'b0;
    for (int e = 0; e <= 16; e++) begin
      step_pos;
      if (e >= 5 && e <= 12) begin
        tests++;
        if (o[1] !== (((e - 5) % 8) < 4)) begin
          fails++;
          $display("FAIL drain_o e%0d: got %b want %b", e, o[1],
                   (((e - 5) % 8) < 4));
        end
      end
      if (e == 12 || e == 13) begin
        tests++;
        if ({act[1], o[1]} !== {(e == 12), 1'b0}) begin
          fails++;
          $display("FAIL drain_end e%0d: got act,o=%b%b", e, act[1], o[1]);
        end
      end
      if (e == 16) begin
        tests++;
        if (pd1 !== 16'd1) begin
          fails++;
          $display("FAIL drain_pulses: got %0d want 1", pd1);
        end
      end
      if (e == 7) begin
        @(negedge CLK);
        ceb[1] = 1'b1;
      end
    end
  endtask

  task automatic test_redrain;
    do_reset;
    @(negedge CLK);
    ceb[1] = 1'b0;
    for (int e = 0; e <= 20; e++) begin
      step_pos;
      if (e >= 5) begin
        tests++;
        if ({act[1], o[1]} !== {1'b1, (((e - 5) % 8) < 4)}) begin
          fails++;
          $display("FAIL redrain e%0d: got act,o=%b%b", e, act[1], o[1]);
        end
      end
      if (e == 20) begin
        tests++;
        if (pd1 !== 16'd2) begin
          fails++;
          $display("FAIL redrain_pulses: got %0d want 2", pd1);
        end
      end
      if (e == 5 || e == 6) begin
        @(negedge CLK);
        ceb[1] = (e == 5);
      end
    end
    do_reset;
    @(negedge CLK);
    ceb[0] = 1'b0;
    for (int e = 0; e <= 12; e++) begin
      step_pos;
      tests++;
      if ({act[0], pd0} !== 17'd0) begin
        fails++;
        $display("FAIL wake_abort e%0d: got act=%b p=%0d want 0 0",
                 e, act[0], pd0);
      end
      if (e == 2) begin
        @(negedge CLK);
        ceb[0] = 1'b1;
      end
    end
  endtask

  task automatic test_passthrough;
    do_reset;
    @(negedge CLK);
    ceb[2] = 1'b0;
    for (int e = 0; e <= 14; e++) begin
      step_pos;
      if (e == 4) begin
        tests++;
        if ({act[2], o[2]} !== 2'b10) begin
          fails++;
          $display("FAIL pass_entry: got act,o=%b%b want 10", act[2], o[2]);
        end
      end
      if (e >= 5 && e <= 13) begin
        tests++;
        if ({o[2], ob[2]} !== {(e <= 12), (e > 12)}) begin
          fails++;
          $display("FAIL pass_high e%0d: got o,ob=%b%b", e, o[2], ob[2]);
        end
      end
      if (e == 12 || e == 13) begin
        tests++;
        if ({act[2], pd2} !== {1'b0, 16'd8}) begin
          fails++;
          $display("FAIL pass_off e%0d: got act=%b p=%0d want 0 8",
                   e, act[2], pd2);
        end
      end
      @(negedge CLK);
      #2;
      tests++;
      if ({o[2], ob[2]} !== 2'b01) begin
        fails++;
        $display("FAIL pass_low e%0d: got o,ob=%b%b want 01", e, o[2], ob[2]);
      end
      if (e == 8) ceb[2] = 1'b1;
    end
  endtask

  task automatic test_random;
    int g;
    do_reset;
    for (int n = 0; n < 800; n++) begin
      @(negedge CLK);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 11) == 0) ceb[i] = ~ceb[i];
      if ($urandom_range(0, 15) == 0) begin
        g = $urandom_range(0, 3);
        #1 ceb[g] = ~ceb[g];
        #2 ceb[g] = ~ceb[g];
      end
      step_pos;
      for (int i = 0; i < 4; i++) begin
        tests++;
        if ({o[i], ob[i], act[i], pd(i)} !==
            {exp_o(i), ~exp_o(i), (st[i] >= 2), mp[i]}) begin
          fails++;
          $display("FAIL random[%0d] n%0d: got o=%b ob=%b act=%b p=%0d want %b %b %b %0d",
                   i, n, o[i], ob[i], act[i], pd(i),
                   exp_o(i), ~exp_o(i), (st[i] >= 2), mp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run;
    do_reset;
    @(negedge CLK);
    ceb[0] = 1'b0;
    ceb[2] = 1'b0;
    repeat (10) step_pos;
    @(posedge CLK);
    #3 RSTN = 1'b0;
    #1;
    tests++;
    if ({o, ob, act} !== 12'h0f0 || {pd0, pd2} !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid: got o=%b ob=%b act=%b p0=%0d p2=%0d want 0000 1111 0000 0 0",
               o, ob, act, pd0, pd2);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    ceb  = 4'hf;
  endtask

  task automatic test_wrap;
    do_reset;
    @(negedge CLK);
    ceb[2] = 1'b0;
    for (int e = 0; e <= 65545; e++) begin
      step_pos;
      if (e == 65539 || e == 65540) begin
        tests++;
        if (pd2 !== ((e == 65539) ? 16'hffff : 16'h0000)) begin
          fails++;
          $display("FAIL wrap e%0d: got %0h", e, pd2);
        end
      end
      if (e % 8192 == 100) begin
        tests++;
        if (pd2 !== mp[2]) begin
          fails++;
          $display("FAIL wrap_model e%0d: got %0h want %0h", e, pd2, mp[2]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_default_enable;
    test_tx_disabled;
    test_drain;
    test_redrain;
    test_passthrough;
    test_random;
    test_reset_mid_run;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
